scan_capture: RTL and testbench
===============================

Name: scan_capture

Overview:
- Upstream producer for the Ethernet session buffer: takes the 8-bit ADC sample stream and cuts one record per transmit trigger (delay, decimation, window length).
- Prefixes each record with a 2-byte sequence header and writes it to the session using its record-level write / byte-strobe / full handshake.
- A small internal FIFO absorbs backpressure while the session is full.

Parameters:
- FIFO_AW, 6, FIFO address width; depth = 2^FIFO_AW bytes.
- CNT_W, 16, width of the delay, length and sample counters.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_adc_data  in  8  ADC sample.
- i_adc_valid  in  1  sample strobe, at most one per cycle.
- i_trig  in  1  transmit-pulse trigger, single-cycle.
- i_arm  in  1  pulse; arms one capture.
- i_cont  in  1  level; re-arm automatically after each record.
- i_stop  in  1  pulse; abort the current capture or disarm.
- i_delay  in  CNT_W  valid samples to skip after trigger.
- i_length  in  CNT_W  stored samples per record.
- i_decim  in  4  keep every (i_decim+1)-th valid sample.
- o_data  out  8  byte to session.
- o_wr  out  1  record window; high for the whole record.
- o_din  out  1  byte-present strobe.
- i_full  in  1  session full; byte not accepted.
- o_busy  out  1  state != IDLE.
- o_overrun  out  1  sticky; a sample was dropped on FIFO full. Cleared by i_arm.
- o_seq  out  16  sequence number of the current or last record.

Behaviour:
- Reset: all outputs 0; FIFO emptied; seq=0; state IDLE. Reset mid-record drops o_wr immediately; no partial flush is guaranteed.
- Accept rule: a byte transfers in any cycle with o_wr & o_din & !i_full. o_data is valid whenever o_din=1 and holds until accepted.
- Config latch: i_delay, i_length and i_decim are sampled into registers when the trigger is accepted. Later input changes do not affect the running record.
- IDLE: i_arm -> ARMED.
- ARMED: i_trig -> DELAY (or CAPTURE if the latched delay=0), and on the same edge:
  - o_wr<=1;
  - header phase = 2;
  - decimation phase = 0.
- ARMED with i_stop -> IDLE.
- Length 0 at trigger: record is header only; go straight to DRAIN.
- DELAY: count valid samples. When the count reaches delay-1 on a valid cycle, next state is CAPTURE. A sample counted in DELAY is never stored.
- CAPTURE:
  - Each valid sample increments the decimation phase; the sample is pushed when phase==0, and phase wraps at i_decim.
  - Pushed-sample counter reaching length -> DRAIN.
  - If the FIFO is full at a push, the sample is dropped, o_overrun<=1, and it still counts toward length.
- i_stop in DELAY or CAPTURE -> DRAIN.
- Output mux while o_wr=1:
  - Header phase 2: o_data = seq[15:8], o_din=1.
  - Header phase 1: o_data = seq[7:0], o_din=1.
  - Header phase 0: o_data = FIFO head, o_din = !fifo_empty.
  - Each accepted byte decrements the header phase until it reaches 0.
- DRAIN: wait for header phase 0 and FIFO empty -> CLOSE.
- CLOSE: o_wr<=0 for exactly one cycle; seq<=seq+1 (wraps 0xFFFF->0). Then:
  - -> ARMED if i_cont=1 and no i_stop seen since trigger;
  - else -> IDLE.
- Triggers outside ARMED are ignored.
- o_wr is never high for two records without an intervening low cycle.
- FIFO push and pop in the same cycle are both performed; occupancy is unchanged.
- i_arm while not IDLE is ignored, except that it still clears o_overrun.

Test Plan:
- Basic record: delay=3, length=4, decim=0, i_full=0, samples 0x10..0x17 valid every cycle, trigger at sample 0x10 → accepted bytes 0x00,0x00,0x13,0x14,0x15,0x16; o_wr then falls for one cycle; seq=1; state IDLE.
- Decimation: decim=2, length=3, delay=0, samples 0..8 → bytes hdr,hdr,0x00,0x03,0x06.
- Backpressure: hold i_full=1 for 20 cycles mid-record with depth 64 → no bytes lost, o_din held, o_data stable, o_overrun=0. Then i_full=1 for >64 samples → o_overrun=1 and record is exactly 2+length bytes minus the dropped count.
- Continuous and wrap:
  - i_cont=1, preload seq=0xFFFF via 65535 records (or force) → headers FF FF then 00 00;
  - ARMED is re-entered after each CLOSE;
  - a trigger during CAPTURE is ignored.
- Abort: i_stop two samples into a length=100 capture → FIFO contents drained, o_wr drops, state IDLE. Length 0 → record is header bytes only.
- Reset mid-CAPTURE: async i_rst_n low → o_wr, o_din, o_busy and o_overrun go 0 immediately; after release the next record has seq=0.

Source files
------------

// File: rtl/scan_capture.sv
// rtl/scan_capture.sv - cuts triggered ADC records (delay, decimation, window) and streams
// them to the session as a 2-byte sequence header followed by buffered samples.
module scan_capture #(
  parameter int FIFO_AW = 6,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_adc_data,
  input  logic             i_adc_valid,
  input  logic             i_trig,
  input  logic             i_arm,
  input  logic             i_cont,
  input  logic             i_stop,
  input  logic [CNT_W-1:0] i_delay,
  input  logic [CNT_W-1:0] i_length,
  input  logic [3:0]       i_decim,
  output logic [7:0]       o_data,
  output logic             o_wr,
  output logic             o_din,
  input  logic             i_full,
  output logic             o_busy,
  output logic             o_overrun,
  output logic [15:0]      o_seq
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_CAPTURE,
    S_DRAIN,
    S_CLOSE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   delay_q, delay_d;
  logic [CNT_W-1:0]   length_q, length_d;
  logic [3:0]         decim_q, decim_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         dphase_q, dphase_d;
  logic [1:0]         hdr_q, hdr_d;
  logic               wr_q, wr_d;
  logic               overrun_q, overrun_d;
  logic [15:0]        seq_q, seq_d;
  logic               stop_seen_q, stop_seen_d;
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   fcnt_q, fcnt_d;
  logic [7:0]         mem_q [DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic din;
  logic accept;
  logic pop;
  logic push_en;
  logic overrun_set;

  // Occupancy tops out at DEPTH, so its MSB alone flags full.
  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = fcnt_q[FIFO_AW];

  assign din    = wr_q & ((hdr_q != 2'd0) | ~fifo_empty);
  assign accept = din & ~i_full;
  assign pop    = accept & (hdr_q == 2'd0);

  always_comb begin
    o_data = 8'h00;
    if (wr_q) begin
      case (hdr_q)
        2'd2:    o_data = seq_q[15:8];
        2'd1:    o_data = seq_q[7:0];
        default: o_data = mem_q[rptr_q];
      endcase
    end
  end

  assign o_wr      = wr_q;
  assign o_din     = din;
  assign o_busy    = (state_q != S_IDLE);
  assign o_overrun = overrun_q;
  assign o_seq     = seq_q;

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    length_d    = length_q;
    decim_d     = decim_q;
    cnt_d       = cnt_q;
    dphase_d    = dphase_q;
    hdr_d       = hdr_q;
    wr_d        = wr_q;
    overrun_d   = overrun_q;
    seq_d       = seq_q;
    stop_seen_d = stop_seen_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    fcnt_d      = fcnt_q;
    push_en     = 1'b0;
    overrun_set = 1'b0;

    if (accept && (hdr_q != 2'd0)) begin
      hdr_d = hdr_q - 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_arm) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (i_stop) begin
          state_d = S_IDLE;
        end else if (i_trig) begin
          delay_d     = i_delay;
          length_d    = i_length;
          decim_d     = i_decim;
          cnt_d       = '0;
          dphase_d    = 4'd0;
          hdr_d       = 2'd2;
          wr_d        = 1'b1;
          stop_seen_d = 1'b0;
          if (i_length == '0) begin
            state_d = S_DRAIN;
          end else if (i_delay == '0) begin
            state_d = S_CAPTURE;
          end else begin
            state_d = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        if (i_stop) begin
          stop_seen_d = 1'b1;
          state_d     = S_DRAIN;
        end else if (i_adc_valid) begin
          if (cnt_q == delay_q - CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_CAPTURE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CAPTURE: begin
        if (i_stop) begin
          stop_seen_d = 1'b1;
          state_d     = S_DRAIN;
        end else if (i_adc_valid) begin
          dphase_d = (dphase_q == decim_q) ? 4'd0 : dphase_q + 4'd1;
          if (dphase_q == 4'd0) begin
            // A dropped sample still consumes a slot of the record window.
            cnt_d = cnt_q + CNT_W'(1);
            if (fifo_full) begin
              overrun_set = 1'b1;
            end else begin
              push_en = 1'b1;
            end
            if ((cnt_q + CNT_W'(1)) == length_q) begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (i_stop) begin
          stop_seen_d = 1'b1;
        end
        if ((hdr_q == 2'd0) && fifo_empty) begin
          wr_d    = 1'b0;
          state_d = S_CLOSE;
        end
      end
      S_CLOSE: begin
        seq_d = seq_q + 16'd1;
        if (i_cont && !stop_seen_q && !i_stop) begin
          state_d = S_ARMED;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (i_arm) begin
      overrun_d = 1'b0;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end

    if (push_en) begin
      wptr_d = wptr_q + FIFO_AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + FIFO_AW'(1);
    end
    fcnt_d = fcnt_q + (FIFO_AW+1)'(push_en) - (FIFO_AW+1)'(pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      delay_q     <= '0;
      length_q    <= '0;
      decim_q     <= 4'd0;
      cnt_q       <= '0;
      dphase_q    <= 4'd0;
      hdr_q       <= 2'd0;
      wr_q        <= 1'b0;
      overrun_q   <= 1'b0;
      seq_q       <= 16'd0;
      stop_seen_q <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      fcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      length_q    <= length_d;
      decim_q     <= decim_d;
      cnt_q       <= cnt_d;
      dphase_q    <= dphase_d;
      hdr_q       <= hdr_d;
      wr_q        <= wr_d;
      overrun_q   <= overrun_d;
      seq_q       <= seq_d;
      stop_seen_q <= stop_seen_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fcnt_q      <= fcnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_en) begin
      mem_q[wptr_q] <= i_adc_data;
    end
  end

endmodule

// File: tb/tb_scan_capture.sv
// tb/tb_scan_capture.sv - directed-vector bench for scan_capture.
module tb_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  adc_data;
  logic        adc_valid;
  logic        trig;
  logic        arm;
  logic        cont;
  logic        stop;
  logic [15:0] delay;
  logic [15:0] length;
  logic [3:0]  decim;
  logic [7:0]  data;
  logic        wr;
  logic        din;
  logic        full;
  logic        busy;
  logic        overrun;
  logic [15:0] seq;

  int vectors = 0;
  int miscompares = 0;
  int falls = 0;
  logic wr_prev = 1'b0;
  logic [7:0] got[$];

  scan_capture #(.FIFO_AW(6), .CNT_W(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_adc_data  (adc_data),
    .i_adc_valid (adc_valid),
    .i_trig      (trig),
    .i_arm       (arm),
    .i_cont      (cont),
    .i_stop      (stop),
    .i_delay     (delay),
    .i_length    (length),
    .i_decim     (decim),
    .o_data      (data),
    .o_wr        (wr),
    .o_din       (din),
    .i_full      (full),
    .o_busy      (busy),
    .o_overrun   (overrun),
    .o_seq       (seq)
  );

  always #5 clk = ~clk;

  // Bytes the session would take at the coming edge.
  always @(negedge clk) begin
    if (wr && din && !full) got.push_back(data);
    if (wr_prev && !wr) falls <= falls + 1;
    wr_prev <= wr;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic do_trig();
    trig = 1'b1;
    adc_valid = 1'b0;
    cyc();
    trig = 1'b0;
  endtask

  task automatic feed(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      adc_data = start + 8'(i);
      adc_valid = 1'b1;
      cyc();
    end
    adc_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic wait_wr_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!wr) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    vectors++; if (wr !== 1'b0) begin miscompares++; $display("FAIL reset_wr got %0b want 0", wr); end
    vectors++; if (din !== 1'b0) begin miscompares++; $display("FAIL reset_din got %0b want 0", din); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %0b want 0", overrun); end
    vectors++; if (seq !== 16'h0000) begin miscompares++; $display("FAIL reset_seq got %h want 0000", seq); end
    vectors++; if (data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", data); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_q[$];
    bit ok;
    int f0;
    exp_q = '{8'h00, 8'h00, 8'h13, 8'h14, 8'h15, 8'h16};
    got.delete();
    f0 = falls;
    delay = 16'd3; length = 16'd4; decim = 4'd0;
    pulse_arm();
    do_trig();
    delay = 16'd0; length = 16'd1; decim = 4'd5;
    feed(8'h10, 8);
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL basic_timeout busy %0b want 0", busy); end
    vectors++; if (got.size() !== exp_q.size()) begin miscompares++; $display("FAIL basic_count got %0d want %0d", got.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      vectors++; if (got[k] !== exp_q[k]) begin miscompares++; $display("FAIL basic_byte%0d got %h want %h", k, got[k], exp_q[k]); end
    end
    vectors++; if (seq !== 16'd1) begin miscompares++; $display("FAIL basic_seq got %h want 0001", seq); end
    vectors++; if (falls - f0 !== 1) begin miscompares++; $display("FAIL basic_wr_falls got %0d want 1", falls - f0); end
  endtask

  task automatic test_decim();
    logic [7:0] exp_q[$];
    bit ok;
    exp_q = '{8'h00, 8'h01, 8'h00, 8'h03, 8'h06};
    got.delete();
    delay = 16'd0; length = 16'd3; decim = 4'd2;
    pulse_arm();
    do_trig();
    feed(8'h00, 9);
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL decim_timeout busy %0b want 0", busy); end
    vectors++; if (got.size() !== exp_q.size()) begin miscompares++; $display("FAIL decim_count got %0d want %0d", got.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      vectors++; if (got[k] !== exp_q[k]) begin miscompares++; $display("FAIL decim_byte%0d got %h want %h", k, got[k], exp_q[k]); end
    end
    vectors++; if (seq !== 16'd2) begin miscompares++; $display("FAIL decim_seq got %h want 0002", seq); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_q[$];
    bit ok;
    exp_q = '{8'h00, 8'h02, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29};
    got.delete();
    delay = 16'd0; length = 16'd10; decim = 4'd0;
    pulse_arm();
    do_trig();
    for (int i = 0; i < 25; i++) begin
      adc_valid = (i < 10);
      adc_data = 8'h20 + 8'(i);
      full = (i >= 3 && i < 23);
      @(negedge clk);
      if (full) begin
        vectors++; if (din !== 1'b1) begin miscompares++; $display("FAIL bp_din_held cycle %0d got %0b want 1", i, din); end
        vectors++; if (data !== 8'h21) begin miscompares++; $display("FAIL bp_data_stable cycle %0d got %h want 21", i, data); end
      end
      @(posedge clk);
      #1;
    end
    adc_valid = 1'b0;
    full = 1'b0;
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_timeout busy %0b want 0", busy); end
    vectors++; if (got.size() !== exp_q.size()) begin miscompares++; $display("FAIL bp_count got %0d want %0d", got.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      vectors++; if (got[k] !== exp_q[k]) begin miscompares++; $display("FAIL bp_byte%0d got %h want %h", k, got[k], exp_q[k]); end
    end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL bp_overrun got %0b want 0", overrun); end

    got.delete();
    length = 16'd80;
    pulse_arm();
    full = 1'b1;
    do_trig();
    feed(8'h00, 80);
    full = 1'b0;
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL ovr_timeout busy %0b want 0", busy); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %0b want 1", overrun); end
    vectors++; if (got.size() !== 66) begin miscompares++; $display("FAIL ovr_count got %0d want 66", got.size()); end
    if (got.size() == 66) begin
      vectors++; if (got[1] !== 8'h03) begin miscompares++; $display("FAIL ovr_hdr_lo got %h want 03", got[1]); end
      for (int k = 0; k < 64; k++) begin
        vectors++; if (got[k+2] !== 8'(k)) begin miscompares++; $display("FAIL ovr_byte%0d got %h want %h", k + 2, got[k+2], 8'(k)); end
      end
    end
    pulse_arm();
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL arm_clears_overrun got %0b want 0", overrun); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL arm_armed got %0b want 1", busy); end
    pulse_stop();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL armed_stop_idle got %0b want 0", busy); end
  endtask

  task automatic test_cont_wrap();
    logic [7:0] exp_q[$];
    bit ok;
    int f0;
    exp_q = '{8'hFF, 8'hFF, 8'h55, 8'h00, 8'h00, 8'h61, 8'h62, 8'h63};
    got.delete();
    force dut.seq_q = 16'hFFFF;
    cyc();
    release dut.seq_q;
    f0 = falls;
    cont = 1'b1;
    delay = 16'd0; length = 16'd1; decim = 4'd0;
    pulse_arm();
    do_trig();
    feed(8'h55, 1);
    wait_wr_low(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL cont_rec1_timeout wr %0b want 0", wr); end
    cyc(); cyc();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL cont_rearm1 busy %0b want 1", busy); end
    vectors++; if (seq !== 16'h0000) begin miscompares++; $display("FAIL seq_wrap got %h want 0000", seq); end
    length = 16'd3;
    do_trig();
    adc_data = 8'h61; adc_valid = 1'b1; cyc();
    trig = 1'b1; adc_data = 8'h62; cyc();
    trig = 1'b0; adc_data = 8'h63; cyc();
    adc_valid = 1'b0;
    wait_wr_low(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL cont_rec2_timeout wr %0b want 0", wr); end
    cyc(); cyc();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL cont_rearm2 busy %0b want 1", busy); end
    cont = 1'b0;
    pulse_stop();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cont_stop busy %0b want 0", busy); end
    vectors++; if (got.size() !== exp_q.size()) begin miscompares++; $display("FAIL cont_count got %0d want %0d", got.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      vectors++; if (got[k] !== exp_q[k]) begin miscompares++; $display("FAIL cont_byte%0d got %h want %h", k, got[k], exp_q[k]); end
    end
    vectors++; if (seq !== 16'd1) begin miscompares++; $display("FAIL cont_seq got %h want 0001", seq); end
    vectors++; if (falls - f0 !== 2) begin miscompares++; $display("FAIL cont_wr_falls got %0d want 2", falls - f0); end
  endtask

  task automatic test_abort();
    logic [7:0] exp_q[$];
    bit ok;
    exp_q = '{8'h00, 8'h01, 8'h70, 8'h71};
    got.delete();
    delay = 16'd0; length = 16'd100; decim = 4'd0;
    pulse_arm();
    do_trig();
    feed(8'h70, 2);
    pulse_stop();
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL abort_timeout busy %0b want 0", busy); end
    vectors++; if (wr !== 1'b0) begin miscompares++; $display("FAIL abort_wr got %0b want 0", wr); end
    vectors++; if (got.size() !== exp_q.size()) begin miscompares++; $display("FAIL abort_count got %0d want %0d", got.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      vectors++; if (got[k] !== exp_q[k]) begin miscompares++; $display("FAIL abort_byte%0d got %h want %h", k, got[k], exp_q[k]); end
    end
    vectors++; if (seq !== 16'd2) begin miscompares++; $display("FAIL abort_seq got %h want 0002", seq); end

    got.delete();
    length = 16'd0;
    pulse_arm();
    do_trig();
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL len0_timeout busy %0b want 0", busy); end
    vectors++; if (got.size() !== 2) begin miscompares++; $display("FAIL len0_count got %0d want 2", got.size()); end
    if (got.size() == 2) begin
      vectors++; if (got[0] !== 8'h00) begin miscompares++; $display("FAIL len0_hdr_hi got %h want 00", got[0]); end
      vectors++; if (got[1] !== 8'h02) begin miscompares++; $display("FAIL len0_hdr_lo got %h want 02", got[1]); end
    end
    vectors++; if (seq !== 16'd3) begin miscompares++; $display("FAIL len0_seq got %h want 0003", seq); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_q[$];
    bit ok;
    exp_q = '{8'h00, 8'h00, 8'h99};
    delay = 16'd0; length = 16'd100; decim = 4'd0;
    pulse_arm();
    full = 1'b1;
    do_trig();
    feed(8'h00, 70);
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_overrun got %0b want 1", overrun); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (wr !== 1'b0) begin miscompares++; $display("FAIL rstmid_wr got %0b want 0", wr); end
    vectors++; if (din !== 1'b0) begin miscompares++; $display("FAIL rstmid_din got %0b want 0", din); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rstmid_overrun got %0b want 0", overrun); end
    cyc();
    rst_n = 1'b1;
    full = 1'b0;
    cyc();
    got.delete();
    length = 16'd1;
    pulse_arm();
    do_trig();
    feed(8'h99, 1);
    wait_idle(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_timeout busy %0b want 0", busy); end
    vectors++; if (got.size() !== exp_q.size()) begin miscompares++; $display("FAIL rstmid_count got %0d want %0d", got.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      vectors++; if (got[k] !== exp_q[k]) begin miscompares++; $display("FAIL rstmid_byte%0d got %h want %h", k, got[k], exp_q[k]); end
    end
    vectors++; if (seq !== 16'd1) begin miscompares++; $display("FAIL rstmid_seq got %h want 0001", seq); end
  endtask

  initial begin
    rst_n = 1'b0;
    adc_data = 8'h00; adc_valid = 1'b0; trig = 1'b0; arm = 1'b0;
    cont = 1'b0; stop = 1'b0; delay = 16'd0; length = 16'd0; decim = 4'd0;
    full = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    test_reset();
    test_basic();
    test_decim();
    test_backpressure();
    test_cont_wrap();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
